eq_i2s_transmitter: RTL and testbench

Output stage placed directly downstream of the 5-band FIR audio equalizer. Accepts the equalizer's wide signed sum, rescales it by an arithmetic right shift, rounds and saturates it to the DAC word width, and serializes it as a standard Philips I2S stream (identical sample on left and right). Generates BCLK/LRCLK from the system clock and buffers one sample with a valid/ready handshake, flagging clipping and underrun.

---
 rtl/eq_i2s_transmitter.sv | 181 ++++++++++++++++++
 tb/tb_eq_i2s_transmitter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_i2s_transmitter.sv
// Equalizer output stage: shift, optional round, saturate to the DAC word and send it as Philips I2S.
// Define EQ_TX_ROUND_EN for round-half-up before the shift; the default build truncates.
//
// state | meaning
// IDLE  | no sample yet; bit-clock divider held, BCLK low, LRCLK high
// LEFT  | left slot (LRCLK low); this word was taken from holding or repeated
// RIGHT | right slot (LRCLK high); same word retransmitted
module eq_i2s_transmitter #(
   parameter int IN_WIDTH   = 31,
   parameter int OUT_WIDTH  = 24,
   parameter int SHIFT      = 7,
   parameter int SLOT_WIDTH = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [IN_WIDTH-1:0] i_data_audio,
   input  logic                i_valid,
   output logic                o_ready,
   output logic                o_bclk,
   output logic                o_lrclk,
   output logic                o_sdata,
   output logic                o_clip,
   output logic                o_underrun
);

   localparam int MID_W = IN_WIDTH - SHIFT + 1;
   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(SLOT_WIDTH);

   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(SLOT_WIDTH - 1);
   localparam logic [BIT_W-1:0] BIT_DATA_END = BIT_W'(OUT_WIDTH);

   localparam logic signed [MID_W-1:0] SAT_MAX = MID_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [MID_W-1:0] SAT_MIN = MID_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));
   localparam logic [OUT_WIDTH-1:0]    WORD_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]    WORD_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

`ifdef EQ_TX_ROUND_EN
   localparam logic signed [IN_WIDTH:0] ROUND_INC = (IN_WIDTH+1)'(64'sd1 <<< (SHIFT - 1));
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   state_t                  state;
   logic [OUT_WIDTH-1:0]    hold_word;
   logic [OUT_WIDTH-1:0]    last_word;
   logic [OUT_WIDTH-1:0]    shift_word;
   logic [DIV_W-1:0]        div_cnt;
   logic [BIT_W-1:0]        bit_idx;

   logic signed [IN_WIDTH:0] ext;
   logic signed [MID_W-1:0]  r;
   logic [OUT_WIDTH-1:0]     sat_word;
   logic                     sat_clip;

   logic hold_full;
   logic accept;
   logic div_tc;
   logic fall_evt;
   logic slot_end;
   logic frame_load;

   // One guard bit above the shifted sum keeps the rounding carry visible to the clamp.
   always_comb begin
`ifdef EQ_TX_ROUND_EN
      ext = $signed({i_data_audio[IN_WIDTH-1], i_data_audio}) + ROUND_INC;
`else
      ext = $signed({i_data_audio[IN_WIDTH-1], i_data_audio});
`endif
      r        = MID_W'(ext >>> SHIFT);
      sat_word = r[OUT_WIDTH-1:0];
      sat_clip = 1'b0;
      if (r > SAT_MAX) begin
         sat_word = WORD_MAX;
         sat_clip = 1'b1;
      end else if (r < SAT_MIN) begin
         sat_word = WORD_MIN;
         sat_clip = 1'b1;
      end
   end

   assign hold_full  = !o_ready;
   assign accept     = i_valid && o_ready;
   assign div_tc     = (div_cnt == DIV_LAST);
   assign fall_evt   = (state != IDLE) && div_tc && o_bclk;
   assign slot_end   = fall_evt && (bit_idx == BIT_LAST);
   // Load looks at the holding flag before this cycle's accept lands, so a coincident
   // accept is kept for the following frame and this frame repeats the last word.
   assign frame_load = ((state == IDLE) && hold_full) || ((state == RIGHT) && slot_end);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         hold_word  <= '0;
         last_word  <= '0;
         shift_word <= '0;
         div_cnt    <= '0;
         bit_idx    <= '0;
         o_ready    <= 1'b1;
         o_bclk     <= 1'b0;
         o_lrclk    <= 1'b1;
         o_sdata    <= 1'b0;
         o_clip     <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         o_clip     <= 1'b0;
         o_underrun <= 1'b0;

         if (accept) begin
            hold_word <= sat_word;
            o_ready   <= 1'b0;
            o_clip    <= sat_clip;
         end else if (frame_load && hold_full) begin
            o_ready <= 1'b1;
         end

         if (frame_load) begin
            if (hold_full) begin
               shift_word <= hold_word;
               last_word  <= hold_word;
            end else begin
               shift_word <= last_word;
               o_underrun <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               div_cnt <= '0;
               bit_idx <= '0;
               o_bclk  <= 1'b0;
               o_sdata <= 1'b0;
               o_lrclk <= 1'b1;
               if (hold_full) begin
                  state   <= LEFT;
                  o_lrclk <= 1'b0;
               end
            end
            LEFT, RIGHT: begin
               if (div_tc) begin
                  div_cnt <= '0;
                  o_bclk  <= !o_bclk;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end

               if (slot_end) begin
                  bit_idx <= '0;
                  o_sdata <= 1'b0;
                  o_lrclk <= !o_lrclk;
                  if (state == LEFT) begin
                     state      <= RIGHT;
                     shift_word <= last_word;
                  end else begin
                     state <= LEFT;
                  end
               end else if (fall_evt) begin
                  bit_idx <= bit_idx + BIT_W'(1);
                  // Bit 0 of each slot is the I2S one-bit delay; data occupies 1..OUT_WIDTH.
                  if (bit_idx < BIT_DATA_END) begin
                     o_sdata    <= shift_word[OUT_WIDTH-1];
                     shift_word <= {shift_word[OUT_WIDTH-2:0], 1'b0};
                  end else begin
                     o_sdata <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eq_i2s_transmitter.sv
// Bench for eq_i2s_transmitter: table of samples, serial-stream monitor with expected-word queue,
// plus underrun, mid-frame reset and continuous-stream sequences.
module tb_eq_i2s_transmitter;
   localparam int IN_WIDTH   = 31;
   localparam int OUT_WIDTH  = 24;
   localparam int SHIFT      = 7;
   localparam int SLOT_WIDTH = 32;
   localparam int BCLK_DIV   = 4;
   localparam int NVEC       = 8;

   logic                i_clk = 1'b0;
   logic                i_reset_n = 1'b0;
   logic [IN_WIDTH-1:0] i_data_audio = '0;
   logic                i_valid = 1'b0;
   logic                o_ready;
   logic                o_bclk;
   logic                o_lrclk;
   logic                o_sdata;
   logic                o_clip;
   logic                o_underrun;

   int     checks = 0;
   int     failures = 0;
   longint cycle = 0;

   logic [OUT_WIDTH-1:0] exp_q[$];

   typedef struct {
      logic [IN_WIDTH-1:0]  din;
      logic [OUT_WIDTH-1:0] word;
      logic                 clip;
   } vec_t;
   vec_t vecs[NVEC];

   eq_i2s_transmitter #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT),
      .SLOT_WIDTH(SLOT_WIDTH),
      .BCLK_DIV  (BCLK_DIV)
   ) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_data_audio(i_data_audio),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_bclk      (o_bclk),
      .o_lrclk     (o_lrclk),
      .o_sdata     (o_sdata),
      .o_clip      (o_clip),
      .o_underrun  (o_underrun)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference: {clip, word} from plain integer arithmetic.
   function automatic logic [OUT_WIDTH:0] model(input logic [IN_WIDTH-1:0] d);
      longint v;
      longint vmax;
      v    = longint'($signed(d));
      vmax = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
`ifdef EQ_TX_ROUND_EN
      v = v + (longint'(1) <<< (SHIFT - 1));
`endif
      v = v >>> SHIFT;
      if (v > vmax) return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
      if (v < -vmax - 1) return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      return {1'b0, v[OUT_WIDTH-1:0]};
   endfunction

   // Serial monitor: decodes slots on rising BCLK and compares against the expected-word queue.
   logic                 prev_bclk, prev_lr, prev_sd, cur_lr, started, exp_unr, pad_bad;
   int                   bit_n = 0;
   int                   frames_seen = 0;
   int                   unr_seen = 0;
   logic [OUT_WIDTH-1:0] cap, cur_exp;
   longint               last_fall = 0;
   longint               lr_period = 0;

   initial forever begin
      @(negedge i_clk);
      if (!i_reset_n) begin
         prev_bclk = 1'b0; prev_lr = 1'b1; prev_sd = 1'b0; cur_lr = 1'b1; started = 1'b0;
         bit_n = 0; cap = '0; cur_exp = '0; pad_bad = 1'b0; exp_unr = 1'b0;
      end else begin
         if (o_underrun) unr_seen++;
         if (prev_lr && !o_lrclk) begin
            if (exp_q.size() > 0) begin
               cur_exp = exp_q.pop_front();
               exp_unr = 1'b0;
            end else begin
               exp_unr = 1'b1;
            end
            check("underrun_at_frame_load", o_underrun, exp_unr);
            lr_period = cycle - last_fall;
            last_fall = cycle;
            frames_seen++;
         end else if (o_underrun) begin
            check("underrun_outside_frame_load", o_underrun, 0);
         end
         if (o_lrclk !== prev_lr) begin
            if (started) check("lrclk_change_on_bclk_fall", {prev_bclk, o_bclk}, 2'b10);
            started = 1'b1;
         end
         if (o_sdata !== prev_sd) check("sdata_change_on_bclk_fall", {prev_bclk, o_bclk}, 2'b10);
         if (!prev_bclk && o_bclk) begin
            if (o_lrclk !== cur_lr) begin
               cur_lr = o_lrclk;
               bit_n  = 0;
            end else begin
               bit_n++;
            end
            if (bit_n >= 1 && bit_n <= OUT_WIDTH) cap = {cap[OUT_WIDTH-2:0], o_sdata};
            else if (o_sdata) pad_bad = 1'b1;
            if (bit_n == SLOT_WIDTH - 1) begin
               if (cur_lr) check("right_slot_word", cap, cur_exp);
               else        check("left_slot_word", cap, cur_exp);
               check("slot_pad_bits_zero", pad_bad, 0);
               pad_bad = 1'b0;
            end
         end
         prev_bclk = o_bclk;
         prev_lr   = o_lrclk;
         prev_sd   = o_sdata;
      end
   end

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_bclk"}, o_bclk, 0);
      check({pfx, "_lrclk"}, o_lrclk, 1);
      check({pfx, "_sdata"}, o_sdata, 0);
      check({pfx, "_ready"}, o_ready, 1);
      check({pfx, "_clip"}, o_clip, 0);
      check({pfx, "_underrun"}, o_underrun, 0);
   endtask

   task automatic wait_frames(input int n);
      int target;
      int budget;
      target = frames_seen + n;
      budget = n * 600 + 50;
      while (frames_seen < target && budget > 0) begin
         @(posedge i_clk);
         budget--;
      end
      #1;
      if (frames_seen < target) check("frame_timeout", frames_seen, target);
   endtask

   // Called #1 after a clock edge; pushes the expectation after the accepting edge.
   task automatic send(input logic [IN_WIDTH-1:0] d, input logic [OUT_WIDTH-1:0] w,
                       input logic c, input string nm);
      int n;
      n = 0;
      while (!o_ready && n < 2000) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      if (!o_ready) begin
         check({nm, "_ready_timeout"}, o_ready, 1);
      end else begin
         i_data_audio = d;
         i_valid      = 1'b1;
         @(posedge i_clk);
         #1;
         i_valid = 1'b0;
         exp_q.push_back(w);
         check({nm, "_ready_low"}, o_ready, 0);
         check({nm, "_clip"}, o_clip, c);
      end
   endtask

   initial begin
      int n;
      int u0;
      int toggles;
      int n_acc;
      int budget;
      int start;
      logic rdy;
      logic [31:0] d;
      logic [OUT_WIDTH:0] m;

`ifdef EQ_TX_ROUND_EN
      vecs[0] = '{31'h0000040, 24'h000001, 1'b0};
      vecs[1] = '{31'h3FFFFFFF, 24'h7FFFFF, 1'b1};
      vecs[2] = '{31'h40000000, 24'h800000, 1'b0};
      vecs[3] = '{31'h7FFFFFFF, 24'h000000, 1'b0};
      vecs[4] = '{31'h12345678, 24'h2468AD, 1'b0};
      vecs[5] = '{31'h3FFFFFBF, 24'h7FFFFF, 1'b0};
      vecs[6] = '{31'h7FFFFF80, 24'hFFFFFF, 1'b0};
      vecs[7] = '{31'h7FFFFF40, 24'hFFFFFF, 1'b0};
`else
      vecs[0] = '{31'h0000040, 24'h000000, 1'b0};
      vecs[1] = '{31'h3FFFFFFF, 24'h7FFFFF, 1'b0};
      vecs[2] = '{31'h40000000, 24'h800000, 1'b0};
      vecs[3] = '{31'h7FFFFFFF, 24'hFFFFFF, 1'b0};
      vecs[4] = '{31'h12345678, 24'h2468AC, 1'b0};
      vecs[5] = '{31'h3FFFFFBF, 24'h7FFFFF, 1'b0};
      vecs[6] = '{31'h7FFFFF80, 24'hFFFFFF, 1'b0};
      vecs[7] = '{31'h7FFFFF40, 24'hFFFFFE, 1'b0};
`endif

      repeat (3) @(posedge i_clk);
      #1;
      check_reset_outputs("por");
      #2 i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;

      for (int i = 0; i < NVEC; i++)
         send(vecs[i].din, vecs[i].word, vecs[i].clip, $sformatf("vec%0d", i));

      // Last vector goes out next frame, then two underrun frames repeat it.
      u0 = unr_seen;
      wait_frames(2);
      wait_frames(1);
      check("underrun_pulse_count", unr_seen - u0, 2);
      check("lrclk_period_cycles", lr_period, 2 * SLOT_WIDTH * 2 * BCLK_DIV);

      // Reset asynchronously in the middle of a right slot.
      wait_frames(1);
      repeat (300) @(posedge i_clk);
      #1;
      check("reset_taken_in_right_slot", o_lrclk, 1);
      #3 i_reset_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      exp_q.delete();
      @(posedge i_clk);
      #2 i_reset_n = 1'b1;
      toggles = 0;
      repeat (600) begin
         @(posedge i_clk);
         #1;
         if (o_bclk || !o_lrclk || !o_ready) toggles++;
      end
      check("idle_until_accept", toggles, 0);
      send(vecs[2].din, vecs[2].word, vecs[2].clip, "post_reset");
      wait_frames(2);

      // Continuous valid: one accept per frame, no underrun while the stream lasts.
      n = 0;
      while (!o_lrclk && n < 1000) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      check("stream_start_in_right_slot", o_lrclk, 1);
      n_acc  = 0;
      budget = 5000;
      d      = $urandom;
      i_data_audio = d[IN_WIDTH-1:0];
      i_valid      = 1'b1;
      start        = frames_seen;
      while ((frames_seen - start) < 6 && budget > 0) begin
         rdy = o_ready;
         @(posedge i_clk);
         #1;
         budget--;
         if (rdy) begin
            m = model(d[IN_WIDTH-1:0]);
            exp_q.push_back(m[OUT_WIDTH-1:0]);
            check("stream_clip", o_clip, m[OUT_WIDTH]);
            check("stream_ready_low_after_accept", o_ready, 0);
            n_acc++;
            d = $urandom;
            if (n_acc == 2) d = 32'h3FFFFFFF;
            if (n_acc == 4) d = 32'h40000000;
            i_data_audio = d[IN_WIDTH-1:0];
         end
      end
      i_valid = 1'b0;
      check("stream_accept_count", n_acc, 7);
      wait_frames(1);
      check("stream_queue_drained", exp_q.size(), 0);
      wait_frames(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
